c8051_int_ctrl: RTL and testbench
=================================

Name: c8051_int_ctrl

Overview:
- Interrupt controller/scheduler for the 8051 core inside `top`.
- Each cycle it polls the five standard interrupt sources against IE/IP. It arbitrates by two-level priority plus fixed in-level order, and presents one request and its vector to the core.
- It tracks in-service levels for nesting, using the core's acknowledge and RETI handshake.

Parameters:
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, address spacing between consecutive source vectors.
- CLR_MASK, 5'b01111, sources whose flag is hardware-cleared on acknowledge (bit4 serial is never cleared).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_pend  in  5  pending flags: [0] IE0, [1] TF0, [2] IE1, [3] TF1, [4] RI|TI; level, held by owner until cleared.
- ie_reg  in  8  IE SFR: [7] EA global enable, [4:0] per-source enables.
- ip_reg  in  5  IP SFR: 1 = high priority for that source.
- int_inhibit  in  1  core is mid-instruction, in RETI, or writing IE/IP; blocks a new request.
- int_ack  in  1  one-cycle pulse: core starts LCALL to int_vector.
- int_reti  in  1  one-cycle pulse: core executes RETI.
- int_req  out  1  interrupt request to core.
- int_vector  out  16  target address, valid while int_req=1.
- int_clr  out  5  one-hot one-cycle pulse clearing the taken source's flag.
- in_service  out  2  [1] high level active, [0] low level active.

Behaviour:
- Reset (reset=0, asynchronous): int_req=0, int_vector=0, int_clr=0, in_service=0, FSM=IDLE.
- Eligibility per source i: src_pend[i] & ie_reg[i] & ie_reg[7].
- Level rule:
  - A high-level source is eligible to request only when in_service[1]=0.
  - A low-level source only when in_service=2'b00.
- Selection: any eligible high-level source beats low-level ones. Within a level, the lowest index wins (IE0>TF0>IE1>TF1>serial).
- Vector = VEC_BASE + idx*VEC_STRIDE, 16-bit wrap; defaults give 0003/000B/0013/001B/0023.
- FSM states: IDLE and REQ.
  - IDLE -> REQ: at the clock edge where a selection exists and int_inhibit=0. int_req and int_vector are registered, so latency is 1 cycle from the eligible source to int_req=1.
  - REQ: selection is recomputed every cycle, ignoring int_inhibit. int_vector tracks the current winner, so a higher-priority arrival replaces it. If no source is eligible anymore (flag cleared, EA=0, IE bit cleared), return to IDLE with int_req=0 next cycle.
  - REQ + int_ack: commit the presented source.
    - Set in_service bit for its level.
    - int_clr[idx] = CLR_MASK[idx] for one cycle.
    - int_req=0, go to IDLE.
  - A new request is not raised in the cycle immediately after ack; int_clr propagation needs that cycle.
- int_ack while int_req=0: ignored, no state change.
- int_reti: clear in_service[1] if set, else in_service[0]. Ignored when in_service=0.
- Same-cycle int_reti and int_ack: apply RETI clear first, then the ack set.
- Nesting:
  - A high-level source may preempt a low in-service routine: in_service goes to 2'b11.
  - Same-level or lower-level sources are never raised while their level, or a higher one, is in service.
- ie_reg/ip_reg changes take effect on the next selection; an already-committed in_service level is unaffected.
- Reset mid-REQ or mid-service: all state cleared immediately, no int_clr pulse.

Test Plan:
- Basic request:
  - Stimulus: ie=8'h81, ip=0, src_pend=5'b00001.
  - Response: int_req=1 one cycle later, vector 16'h0003. Ack gives int_clr=5'b00001 for 1 cycle, in_service=01. RETI gives in_service=00.
- Priority within and across levels:
  - Stimulus: ie=8'h9F, ip=0, src_pend=5'b11010.
  - Response: vector 000B (TF0). With ip=5'b10000: vector 0023. Ack on serial gives int_clr=0, in_service=10.
- Nesting:
  - Stimulus: low TF1 acked (in_service=01). Then IE1 asserted with ip[2]=1.
  - Response: int_req with vector 0013. Ack gives in_service=11. Two RETIs give 01, then 00.
  - Also: a low IE0 during in_service=01 gets no int_req.
- Withdrawal and replacement:
  - In REQ on TF1, drop EA: int_req=0 next cycle, FSM in IDLE.
  - Repeat, but assert IE0 instead of dropping EA: int_vector changes to 0003 before ack.
- Inhibit and edge cases:
  - int_inhibit=1 with eligible source: no int_req until inhibit drops, then 1 cycle later.
  - Ack with int_req=0, or RETI with in_service=0: no change.
  - reset=0 while in_service=11 and REQ: all outputs 0 asynchronously.

Source files
------------

// File: rtl/c8051_int_ctrl.sv
// 8051 interrupt scheduler: polls five sources against IE/IP, presents one
// request plus its vector to the core, and tracks in-service levels for nesting.
module c8051_int_ctrl #(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter int unsigned VEC_STRIDE = 8,
  parameter logic [4:0]  CLR_MASK   = 5'b01111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  src_pend,
  input  logic [7:0]  ie_reg,
  input  logic [4:0]  ip_reg,
  input  logic        int_inhibit,
  input  logic        int_ack,
  input  logic        int_reti,
  output logic        int_req,
  output logic [15:0] int_vector,
  output logic [4:0]  int_clr,
  output logic [1:0]  in_service
);

  // state | meaning
  // IDLE  | no request presented; waiting for an eligible, uninhibited source
  // REQ   | int_req asserted; winner re-arbitrated every cycle until ack/withdrawal
  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t      state_q, state_d;
  logic        int_req_q, int_req_d;
  logic [15:0] int_vector_q, int_vector_d;
  logic [4:0]  int_clr_q, int_clr_d;
  logic [1:0]  in_service_q, in_service_d;
  logic [2:0]  idx_q, idx_d;
  logic        lvl_q, lvl_d;
  logic        skip_q, skip_d;

  logic [4:0]  elig, hi_cand, lo_cand, cand;
  logic        sel_valid, sel_hi;
  logic [2:0]  sel_idx;
  logic [15:0] sel_vec;
  logic [1:0]  ins_ret;

  always_comb begin
    elig      = src_pend & ie_reg[4:0] & {5{ie_reg[7]}};
    hi_cand   = elig & ip_reg & {5{~in_service_q[1]}};
    lo_cand   = elig & ~ip_reg & {5{in_service_q == 2'b00}};
    sel_hi    = |hi_cand;
    cand      = sel_hi ? hi_cand : lo_cand;
    sel_valid = |cand;
    sel_idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (cand[i]) sel_idx = 3'(i);
    end
    sel_vec = VEC_BASE + 16'(sel_idx) * 16'(VEC_STRIDE);
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_vector_d = int_vector_q;
    int_clr_d    = 5'b00000;
    idx_d        = idx_q;
    lvl_d        = lvl_q;
    skip_d       = 1'b0;

    // RETI retires the innermost level before any same-cycle ack sets one
    ins_ret = in_service_q;
    if (int_reti) begin
      if (in_service_q[1]) ins_ret[1] = 1'b0;
      else                 ins_ret[0] = 1'b0;
    end
    in_service_d = ins_ret;

    case (state_q)
      ST_IDLE: begin
        // skip_q holds off one cycle after ack so the cleared flag can settle
        if (sel_valid && !int_inhibit && !skip_q) begin
          state_d      = ST_REQ;
          int_req_d    = 1'b1;
          int_vector_d = sel_vec;
          idx_d        = sel_idx;
          lvl_d        = sel_hi;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          in_service_d[lvl_q] = 1'b1;
          int_clr_d    = (5'b00001 << idx_q) & CLR_MASK;
          state_d      = ST_IDLE;
          int_req_d    = 1'b0;
          int_vector_d = 16'h0000;
          skip_d       = 1'b1;
        end else if (sel_valid) begin
          int_vector_d = sel_vec;
          idx_d        = sel_idx;
          lvl_d        = sel_hi;
        end else begin
          state_d      = ST_IDLE;
          int_req_d    = 1'b0;
          int_vector_d = 16'h0000;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        int_req_d    = 1'b0;
        int_vector_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      int_vector_q <= 16'h0000;
      int_clr_q    <= 5'b00000;
      in_service_q <= 2'b00;
      idx_q        <= 3'd0;
      lvl_q        <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
      int_clr_q    <= int_clr_d;
      in_service_q <= in_service_d;
      idx_q        <= idx_d;
      lvl_q        <= lvl_d;
      skip_q       <= skip_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;
  assign int_clr    = int_clr_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_c8051_int_ctrl.sv
// Bench for c8051_int_ctrl: directed scenarios plus a randomized run against
// a queue-based model of the interrupt priority rules.
module tb_c8051_int_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  src_pend = '0;
  logic [7:0]  ie_reg = '0;
  logic [4:0]  ip_reg = '0;
  logic        int_inhibit = 1'b0;
  logic        int_ack = 1'b0;
  logic        int_reti = 1'b0;
  logic        int_req;
  logic [15:0] int_vector;
  logic [4:0]  int_clr;
  logic [1:0]  in_service;

  int total = 0;
  int bad = 0;

  c8051_int_ctrl dut (
    .clock(clock), .reset(reset), .src_pend(src_pend), .ie_reg(ie_reg),
    .ip_reg(ip_reg), .int_inhibit(int_inhibit), .int_ack(int_ack),
    .int_reti(int_reti), .int_req(int_req), .int_vector(int_vector),
    .int_clr(int_clr), .in_service(in_service)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    src_pend = '0; ie_reg = '0; ip_reg = '0;
    int_inhibit = 0; int_ack = 0; int_reti = 0;
    reset = 0;
    tick; tick;
    reset = 1;
    tick;
  endtask

  task automatic test_reset;
    reset = 0;
    tick;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", int_req); end
    total++; if (int_vector !== 16'h0) begin bad++; $display("FAIL reset_vec got=%h exp=0000", int_vector); end
    total++; if (int_clr !== 5'b0) begin bad++; $display("FAIL reset_clr got=%b exp=00000", int_clr); end
    total++; if (in_service !== 2'b00) begin bad++; $display("FAIL reset_ins got=%b exp=00", in_service); end
    do_reset;
  endtask

  task automatic test_basic;
    ie_reg = 8'h81; ip_reg = 0; src_pend = 5'b00001;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_latency got=%b exp=0", int_req); end
    tick;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", int_req); end
    total++; if (int_vector !== 16'h0003) begin bad++; $display("FAIL basic_vec got=%h exp=0003", int_vector); end
    int_ack = 1; tick; int_ack = 0;
    total++; if (int_clr !== 5'b00001) begin bad++; $display("FAIL basic_clr got=%b exp=00001", int_clr); end
    total++; if (in_service !== 2'b01) begin bad++; $display("FAIL basic_ins got=%b exp=01", in_service); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_after_ack got=%b exp=0", int_req); end
    src_pend = 0; tick;
    total++; if (int_clr !== 5'b0) begin bad++; $display("FAIL basic_clr_pulse got=%b exp=00000", int_clr); end
    int_reti = 1; tick; int_reti = 0;
    total++; if (in_service !== 2'b00) begin bad++; $display("FAIL basic_reti got=%b exp=00", in_service); end
  endtask

  task automatic test_priority;
    ie_reg = 8'h9F; ip_reg = 0; src_pend = 5'b11010;
    tick;
    total++; if (int_vector !== 16'h000B || int_req !== 1'b1) begin bad++; $display("FAIL prio_low got=%b/%h exp=1/000B", int_req, int_vector); end
    ip_reg = 5'b10000; tick;
    total++; if (int_vector !== 16'h0023 || int_req !== 1'b1) begin bad++; $display("FAIL prio_high got=%b/%h exp=1/0023", int_req, int_vector); end
    int_ack = 1; tick; int_ack = 0;
    total++; if (int_clr !== 5'b0) begin bad++; $display("FAIL prio_serial_clr got=%b exp=00000", int_clr); end
    total++; if (in_service !== 2'b10) begin bad++; $display("FAIL prio_ins got=%b exp=10", in_service); end
    src_pend = 0; int_reti = 1; tick; int_reti = 0; ip_reg = 0; tick;
    total++; if (in_service !== 2'b00) begin bad++; $display("FAIL prio_cleanup got=%b exp=00", in_service); end
  endtask

  task automatic test_nesting;
    ie_reg = 8'h8F; ip_reg = 0; src_pend = 5'b01000;
    tick;
    total++; if (int_vector !== 16'h001B) begin bad++; $display("FAIL nest_tf1_vec got=%h exp=001B", int_vector); end
    int_ack = 1; tick; int_ack = 0; src_pend = 0;
    total++; if (in_service !== 2'b01 || int_clr !== 5'b01000) begin bad++; $display("FAIL nest_tf1_ack got=%b/%b exp=01/01000", in_service, int_clr); end
    tick;
    src_pend = 5'b00001; tick; tick;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL nest_low_blocked got=%b exp=0", int_req); end
    src_pend = 5'b00101; ip_reg = 5'b00100; tick;
    total++; if (int_req !== 1'b1 || int_vector !== 16'h0013) begin bad++; $display("FAIL nest_high_req got=%b/%h exp=1/0013", int_req, int_vector); end
    int_ack = 1; tick; int_ack = 0; src_pend = 5'b00001;
    total++; if (in_service !== 2'b11) begin bad++; $display("FAIL nest_ins11 got=%b exp=11", in_service); end
    int_reti = 1; tick;
    total++; if (in_service !== 2'b01 || int_req !== 1'b0) begin bad++; $display("FAIL nest_reti1 got=%b/%b exp=01/0", in_service, int_req); end
    tick; int_reti = 0;
    total++; if (in_service !== 2'b00 || int_req !== 1'b0) begin bad++; $display("FAIL nest_reti2 got=%b/%b exp=00/0", in_service, int_req); end
    tick;
    total++; if (int_req !== 1'b1 || int_vector !== 16'h0003) begin bad++; $display("FAIL nest_ie0_after got=%b/%h exp=1/0003", int_req, int_vector); end
    src_pend = 0; ip_reg = 0; tick; tick;
  endtask

  task automatic test_withdraw;
    ie_reg = 8'h88; ip_reg = 0; src_pend = 5'b01000;
    tick;
    total++; if (int_req !== 1'b1 || int_vector !== 16'h001B) begin bad++; $display("FAIL wd_req got=%b/%h exp=1/001B", int_req, int_vector); end
    ie_reg = 8'h08; tick;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL wd_ea_drop got=%b exp=0", int_req); end
    tick;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b exp=0", int_req); end
    ie_reg = 8'h89; tick;
    total++; if (int_req !== 1'b1 || int_vector !== 16'h001B) begin bad++; $display("FAIL rep_req got=%b/%h exp=1/001B", int_req, int_vector); end
    src_pend = 5'b01001; tick;
    total++; if (int_req !== 1'b1 || int_vector !== 16'h0003) begin bad++; $display("FAIL rep_vec got=%b/%h exp=1/0003", int_req, int_vector); end
    int_ack = 1; tick; int_ack = 0; src_pend = 0;
    total++; if (int_clr !== 5'b00001 || in_service !== 2'b01) begin bad++; $display("FAIL rep_ack got=%b/%b exp=00001/01", int_clr, in_service); end
    int_reti = 1; tick; int_reti = 0; tick;
  endtask

  task automatic test_inhibit_edge;
    ie_reg = 8'h81; ip_reg = 0; src_pend = 5'b00001; int_inhibit = 1;
    tick; tick; tick;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL inh_block got=%b exp=0", int_req); end
    int_inhibit = 0; tick;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL inh_release got=%b exp=1", int_req); end
    src_pend = 0; tick;
    int_ack = 1; tick; int_ack = 0;
    total++; if (in_service !== 2'b00 || int_clr !== 5'b0 || int_req !== 1'b0) begin bad++; $display("FAIL stray_ack got=%b/%b/%b exp=00/00000/0", in_service, int_clr, int_req); end
    int_reti = 1; tick; int_reti = 0;
    total++; if (in_service !== 2'b00) begin bad++; $display("FAIL stray_reti got=%b exp=00", in_service); end
    // build in_service=11, then reset between clock edges
    ie_reg = 8'h8C; ip_reg = 5'b00100; src_pend = 5'b01000;
    tick; int_ack = 1; tick; int_ack = 0; src_pend = 5'b00100;
    tick; tick;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL arst_setup_req got=%b exp=1", int_req); end
    int_ack = 1; tick; int_ack = 0;
    total++; if (in_service !== 2'b11) begin bad++; $display("FAIL arst_setup_ins got=%b exp=11", in_service); end
    src_pend = 5'b01100; #2 reset = 0; #1;
    total++; if (int_req !== 0 || int_vector !== 0 || int_clr !== 0 || in_service !== 0) begin bad++; $display("FAIL async_reset got=%b/%h/%b/%b exp=0", int_req, int_vector, int_clr, in_service); end
    do_reset;
  endtask

  task automatic test_random;
    int stk[$];
    bit m_req = 0, m_lvl = 0, m_skip = 0, ins1, best_lvl;
    int m_idx = 0, best;
    logic [4:0] e_clr;
    logic [1:0] e_ins;
    logic [4:0] clr_mask = 5'b01111;
    do_reset;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if ($urandom_range(3) == 0) src_pend = 5'($urandom);
      if ($urandom_range(3) == 0) ie_reg = {($urandom_range(7) != 0), 2'b00, 5'($urandom)};
      if ($urandom_range(3) == 0) ip_reg = 5'($urandom);
      int_inhibit = ($urandom_range(3) == 0);
      int_ack = ($urandom_range(2) == 0);
      int_reti = ($urandom_range(7) == 0);

      ins1 = 0;
      foreach (stk[k]) if (stk[k] == 1) ins1 = 1;
      best = -1;
      for (int i = 0; i < 5; i++)
        if (best < 0 && src_pend[i] && ie_reg[i] && ie_reg[7] && ip_reg[i] && !ins1) best = i;
      for (int i = 0; i < 5; i++)
        if (best < 0 && src_pend[i] && ie_reg[i] && ie_reg[7] && !ip_reg[i] && stk.size() == 0) best = i;
      best_lvl = (best >= 0) ? ip_reg[best] : 1'b0;

      if (int_reti && stk.size() > 0) void'(stk.pop_back());
      e_clr = 0;
      if (m_req && int_ack) begin
        stk.push_back(int'(m_lvl));
        e_clr = clr_mask & (5'b00001 << m_idx);
        m_req = 0; m_skip = 1;
      end else if (m_req) begin
        if (best >= 0) begin m_idx = best; m_lvl = best_lvl; end
        else m_req = 0;
        m_skip = 0;
      end else begin
        if (!m_skip && best >= 0 && !int_inhibit) begin m_req = 1; m_idx = best; m_lvl = best_lvl; end
        m_skip = 0;
      end

      tick;
      e_ins = 2'b00;
      foreach (stk[k]) e_ins[stk[k]] = 1'b1;
      total++; if (int_req !== m_req) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, int_req, m_req); end
      if (m_req) begin
        total++; if (int_vector !== 16'(3 + 8 * m_idx)) begin bad++; $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", cyc, int_vector, 16'(3 + 8 * m_idx)); end
      end
      total++; if (int_clr !== e_clr) begin bad++; $display("FAIL rnd_clr cyc=%0d got=%b exp=%b", cyc, int_clr, e_clr); end
      total++; if (in_service !== e_ins) begin bad++; $display("FAIL rnd_ins cyc=%0d got=%b exp=%b", cyc, in_service, e_ins); end
    end
    int_ack = 0; int_reti = 0; int_inhibit = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_nesting;
    test_withdraw;
    test_inhibit_edge;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
